rr_shared_latch_arbiter: RTL and testbench

//  Shares one WIDTH-bit holding register (latch + N:1 select mux) among N requesters.

---
 rtl/rr_shared_latch_arbiter.sv | 99 +++++++++
 tb/tb_rr_shared_latch_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_shared_latch_arbiter.sv
// Round-robin arbiter in front of one shared holding register.
// Each cycle at most one requester is granted; its word is captured and
// presented downstream under a valid/ready handshake. A drain and a new
// capture can happen in the same cycle, giving one word per cycle.
module rr_shared_latch_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_src
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic             state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  src_q, src_d;

  logic             can_accept;
  logic             found;
  logic             grant;
  logic [IDXW-1:0]  winner;
  int unsigned      idx_c;

  // Flush frees the register even under backpressure; the dropped word is lost.
  assign can_accept = (state_q == StEmpty) || out_ready || flush;

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_c  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = (32'(ptr_q) + k) % N;
      if (!found && req_valid[idx_c[IDXW-1:0]]) begin
        found  = 1'b1;
        winner = idx_c[IDXW-1:0];
      end
    end
  end

  assign grant = can_accept && found;

  // One-hot grant to the winner, only when the register can take a word.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Next-state: capture has priority, then drain/flush to empty, else hold.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (grant) begin
      state_d = StFull;
      data_d  = req_data[32'(winner)*WIDTH +: WIDTH];
      src_d   = winner;
      ptr_d   = (winner == IDXW'(N - 1)) ? '0 : winner + 1'b1;
    end else if (flush || ((state_q == StFull) && out_ready)) begin
      // Held word leaves; out_data/out_src keep their last value.
      state_d = StEmpty;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_shared_latch_arbiter.sv
// Bench for rr_shared_latch_arbiter: directed phases then random traffic,
// checked by a queue-based scoreboard fed from a behavioural model.
module tb_rr_shared_latch_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] s;
  } word_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;

  rr_shared_latch_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: held words (at most one) and per-cycle expected grants.
  word_t        sb[$];
  logic [N-1:0] gq[$];

  // Model state: pointer, whether a word is held, capture pending for next edge.
  int    m_ptr = 0;
  bit    m_full = 0;
  bit    pend_v = 0;
  word_t pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides the grant from the rules.
  task automatic step(input logic [N-1:0] rv, input logic [N*W-1:0] d,
                      input logic ordy, input logic fl);
    int w;
    bit can;
    logic [N-1:0] exp_rr;
    @(posedge clk);
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    #1;
    req_valid = rv;
    req_data  = d;
    out_ready = ordy;
    flush     = fl;
    can = !m_full || ordy || fl;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && rv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    exp_rr = '0;
    if (can && w >= 0) begin
      exp_rr[w] = 1'b1;
      pend.d = d[w*W +: W];
      pend.s = IW'(w);
      pend_v = 1;
      m_full = 1;
      m_ptr  = (w + 1) % N;
    end else if (fl || (m_full && ordy)) begin
      m_full = 0;
    end
    gq.push_back(exp_rr);
  endtask

  // Asynchronous reset pulse placed between clock edges while a word is held.
  task automatic mid_reset();
    @(posedge clk);
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    req_valid = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_data", 64'(out_data), 64'(0));
    chk("async_rst_src", 64'(out_src), 64'(0));
    reset = 1'b0;
    sb.delete();
    m_ptr  = 0;
    m_full = 0;
    gq.push_back('0);
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: sample mid-cycle, compare against scoreboard, pop consumed words.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gq.size() > 0) chk("req_ready", 64'(req_ready), 64'(gq.pop_front()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() > 0) begin
          chk("out_data", 64'(out_data), 64'(sb[0].d));
          chk("out_src", 64'(out_src), 64'(sb[0].s));
          if (out_ready || flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    #23;
    reset = 1'b0;
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));
    chk("reset_src", 64'(out_src), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));

    // Idle after reset.
    for (int i = 0; i < 10; i++) step('0, rnd_data(), 1'b1, 1'b0);
    chk("idle_data", 64'(out_data), 64'(0));

    // Single requester 2 with 0xCAFE.
    d = rnd_data();
    d[2*W +: W] = 32'hCAFE;
    step(4'b0100, d, 1'b1, 1'b0);
    step('0, rnd_data(), 1'b0, 1'b0);
    step('0, rnd_data(), 1'b1, 1'b0);

    // All valid, consumer always ready: grants rotate 3,0,1,2,...
    for (int i = 0; i < 8; i++) step(4'hF, rnd_data(), 1'b1, 1'b0);

    // Backpressure for 5 cycles, then one accept cycle.
    for (int i = 0; i < 5; i++) step(4'hF, rnd_data(), 1'b0, 1'b0);
    step(4'hF, rnd_data(), 1'b1, 1'b0);

    // Flush while full with no requests, then confirm the pointer held.
    step('0, rnd_data(), 1'b0, 1'b1);
    step('0, rnd_data(), 1'b0, 1'b0);
    step(4'hF, rnd_data(), 1'b1, 1'b0);

    // Flush together with a request under backpressure.
    step(4'hF, rnd_data(), 1'b0, 1'b1);

    // Async reset while full, then verify the pointer restarted at 0.
    mid_reset();
    step(4'hF, rnd_data(), 1'b1, 1'b0);
    step(4'b1000, rnd_data(), 1'b1, 1'b0);
    step(4'b1000, rnd_data(), 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(N'($urandom), rnd_data(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end

    // Drain.
    for (int i = 0; i < 3; i++) step('0, rnd_data(), 1'b1, 1'b0);
    @(posedge clk);
    if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    @(negedge clk);
    #1;
    chk("final_empty", 64'(sb.size()), 64'(0));
    chk("final_valid", 64'(out_valid), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
